dac_capture_buffer: RTL and testbench

DAC_CAPTURE_BUFFER -- requirements
Module: dac_capture_buffer

---
 rtl/dac_capture_pkg.sv | 19 +
 rtl/capture_ram.sv | 31 +++
 rtl/dac_capture_buffer.sv | 150 +++++++++++++++
 tb/tb_dac_capture_buffer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_capture_pkg.sv
// Shared types and helpers for the DAC capture buffer: FSM state encoding
// and the address-width helper used to size the RAM and the beat counter.
package dac_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam int SAMPLE_W = 16;
    localparam int LINE_W   = 2 * SAMPLE_W;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset,
// read-before-write so a same-address collision returns the old word.
module capture_ram #(
    parameter int W     = 256,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dac_capture_buffer.sv
// Triggered capture of the DAC beat stream into block RAM with readback.
// Immediate or rising-edge level trigger on line-0 I; length sampled at arm.
module dac_capture_buffer
    import dac_capture_pkg::*;
#(
    parameter int  NUMBER_OF_LINE = 8,
    parameter int  DEPTH          = 1024,
    localparam int W              = LINE_W * NUMBER_OF_LINE,
    localparam int AW             = addr_width(DEPTH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                s_tvalid,
    input  logic [W-1:0]        s_tdata,
    output logic                s_tready,
    input  logic                arm,
    input  logic                abort,
    input  logic                trig_mode,
    input  logic [15:0]         trig_level,
    input  logic [AW:0]         capture_len,
    input  logic [AW-1:0]       rd_addr,
    input  logic                rd_en,
    output logic [W-1:0]        rd_data,
    output logic                rd_valid,
    output logic [1:0]          state_o,
    output logic                done,
    output logic [AW:0]         captured_cnt
);

    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    // A zero or oversize request means "fill the whole buffer".
    function automatic logic [AW:0] clamp_len(input logic [AW:0] len);
        if (len == '0 || len > LEN_MAX) begin
            return LEN_MAX;
        end
        return len;
    endfunction

    state_e                     state_q, state_d;
    logic [AW:0]                cnt_q, cnt_d, cnt_inc;
    logic [AW:0]                len_q, len_d;
    logic                       mode_q, mode_d;
    logic                       seen_q, seen_d;
    logic signed [SAMPLE_W-1:0] prev_i0_q, prev_i0_d;
    logic                       done_q, rd_valid_q;
    logic signed [SAMPLE_W-1:0] cur_i0, trig_lvl;
    logic                       trig_hit, we;
    logic [AW-1:0]              waddr;
    logic [W-1:0]               ram_rdata;

    assign cur_i0   = s_tdata[SAMPLE_W-1:0];
    assign trig_lvl = trig_level;
    assign cnt_inc  = cnt_q + CNT_ONE;
    assign trig_hit = ~mode_q | (seen_q & (prev_i0_q < trig_lvl) & (cur_i0 >= trig_lvl));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        mode_d    = mode_q;
        seen_d    = seen_q;
        prev_i0_d = prev_i0_q;
        we        = 1'b0;
        waddr     = cnt_q[AW-1:0];
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_d = ST_ARMED;
                        cnt_d   = '0;
                        seen_d  = 1'b0;
                        len_d   = clamp_len(capture_len);
                        mode_d  = trig_mode;
                    end
                end
                ST_ARMED: begin
                    if (s_tvalid) begin
                        seen_d    = 1'b1;
                        prev_i0_d = cur_i0;
                        if (trig_hit) begin
                            we      = 1'b1;
                            waddr   = '0;
                            cnt_d   = CNT_ONE;
                            state_d = (len_q == CNT_ONE) ? ST_DONE : ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (s_tvalid) begin
                        we    = 1'b1;
                        cnt_d = cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Control state: reset returns to IDLE and clears the counters/flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            seen_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            done_q     <= (state_d == ST_DONE);
            rd_valid_q <= rd_en;
        end
    end

    always_ff @(posedge clock) begin
        len_q     <= len_d;
        mode_q    <= mode_d;
        prev_i0_q <= prev_i0_d;
    end

    capture_ram #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clock (clock),
        .we    (we & ~reset),
        .waddr (waddr),
        .wdata (s_tdata),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    assign s_tready     = 1'b1;
    assign rd_data      = rd_valid_q ? ram_rdata : '0;
    assign rd_valid     = rd_valid_q;
    assign state_o      = state_q;
    assign done         = done_q;
    assign captured_cnt = cnt_q;

endmodule

// File: tb/tb_dac_capture_buffer.sv
// Bench for dac_capture_buffer: directed sequences, a queue-based capture
// model checked every cycle, and hand-computed literal expectations.
module tb_dac_capture_buffer;

    localparam int NL    = 8;
    localparam int DEPTH = 1024;
    localparam int W     = 32 * NL;
    localparam int AW    = 10;

    logic          clock = 1'b0;
    logic          reset, s_tvalid, s_tready, arm, abort, trig_mode;
    logic [W-1:0]  s_tdata, rd_data;
    logic [15:0]   trig_level;
    logic [AW:0]   capture_len, captured_cnt;
    logic [AW-1:0] rd_addr;
    logic          rd_en, rd_valid, done;
    logic [1:0]    state_o;

    int total = 0;
    int bad   = 0;

    dac_capture_buffer #(.NUMBER_OF_LINE(NL), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .s_tvalid     (s_tvalid),
        .s_tdata      (s_tdata),
        .s_tready     (s_tready),
        .arm          (arm),
        .abort        (abort),
        .trig_mode    (trig_mode),
        .trig_level   (trig_level),
        .capture_len  (capture_len),
        .rd_addr      (rd_addr),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .state_o      (state_o),
        .done         (done),
        .captured_cnt (captured_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_ARMED = 1, M_CAPTURE = 2, M_DONE = 3;
    int                 m_state = M_IDLE;
    logic [W-1:0]       cap_q[$];
    int                 m_len;
    bit                 m_mode, m_seen, m_fire, started;
    logic signed [15:0] m_prev, m_cur;
    bit                 m_rd_valid, m_rd_known;
    logic [W-1:0]       m_rd_data;
    logic [W-1:0]       m_mem [DEPTH];
    bit                 m_wr [DEPTH];

    always @(posedge clock) begin
        m_cur      = s_tdata[15:0];
        m_rd_valid = !reset && rd_en;
        if (rd_en) begin
            m_rd_data  = m_mem[rd_addr];
            m_rd_known = m_wr[rd_addr];
        end
        if (reset) begin
            m_state = M_IDLE;
            cap_q.delete();
            m_seen  = 0;
            started = 1;
        end else if (abort) begin
            m_state = M_IDLE;
        end else if (arm && (m_state == M_IDLE || m_state == M_DONE)) begin
            m_state = M_ARMED;
            cap_q.delete();
            m_seen  = 0;
            m_mode  = trig_mode;
            m_len   = (capture_len == 0 || capture_len > DEPTH) ? DEPTH : int'(capture_len);
        end else if (s_tvalid && (m_state == M_ARMED || m_state == M_CAPTURE)) begin
            m_fire = (m_state == M_CAPTURE) || !m_mode ||
                     (m_seen && m_prev < $signed(trig_level) && m_cur >= $signed(trig_level));
            if (m_state == M_ARMED) begin
                m_seen = 1;
                m_prev = m_cur;
            end
            if (m_fire) begin
                m_mem[cap_q.size()] = s_tdata;
                m_wr[cap_q.size()]  = 1;
                cap_q.push_back(s_tdata);
                m_state = (cap_q.size() == m_len) ? M_DONE : M_CAPTURE;
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            check("state", W'(state_o), W'(m_state));
            check("done", W'(done), W'(m_state == M_DONE));
            check("captured_cnt", W'(captured_cnt), W'(cap_q.size()));
            check("s_tready", W'(s_tready), W'(1));
            check("rd_valid", W'(rd_valid), W'(m_rd_valid));
            if (!m_rd_valid) check("rd_data_idle", rd_data, '0);
            else if (m_rd_known) check("rd_data", rd_data, m_rd_data);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [W-1:0] mk(input int i0, input int tag);
        logic [W-1:0] b;
        b = '0;
        for (int l = 0; l < NL; l++) begin
            b[32*l +: 16]    = (l == 0) ? 16'(i0) : 16'(tag * 7 + l);
            b[32*l+16 +: 16] = 16'(tag + l);
        end
        return b;
    endfunction

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic beat(input bit v, input logic [W-1:0] d);
        s_tvalid = v;
        s_tdata  = d;
        tick();
        s_tvalid = 1'b0;
    endtask

    task automatic do_arm(input bit mode, input int len, input int lvl);
        trig_mode   = mode;
        capture_len = (AW+1)'(len);
        trig_level  = 16'(lvl);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        // later changes must not affect the running sequence
        capture_len = (AW+1)'(2);
        trig_mode   = ~mode;
        check("lit_armed", W'(state_o), W'(1));
        check("lit_arm_cnt", W'(captured_cnt), W'(0));
    endtask

    task automatic rd(input int a, input logic [W-1:0] exp, input string name);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        tick();
        rd_en = 1'b0;
        check(name, rd_data, exp);
    endtask

    initial begin
        reset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; arm = 1'b0; abort = 1'b0;
        trig_mode = 1'b0; trig_level = '0; capture_len = '0; rd_addr = '0; rd_en = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("lit_rst_state", W'(state_o), W'(0));
        check("lit_rst_cnt", W'(captured_cnt), W'(0));
        check("lit_rst_done", W'(done), W'(0));
        check("lit_rst_rd_valid", W'(rd_valid), W'(0));
        check("lit_rst_rd_data", rd_data, '0);

        // immediate trigger, 4 beats out of 6
        do_arm(1'b0, 4, 0);
        for (int v = 1; v <= 6; v++) begin
            beat(1'b1, W'(v));
            if (v == 3) check("lit_imm_cap", W'(state_o), W'(2));
            if (v == 4) check("lit_imm_done", W'(state_o), W'(3));
        end
        check("lit_imm_cnt", W'(captured_cnt), W'(4));
        check("lit_imm_done_o", W'(done), W'(1));
        for (int a = 0; a < 4; a++) rd(a, W'(a + 1), "lit_imm_rd");

        // level trigger on rising crossing of 100
        do_arm(1'b1, 8, 100);
        beat(1'b1, mk(50, 1));
        beat(1'b1, mk(99, 2));
        check("lit_lvl_wait", W'(state_o), W'(1));
        beat(1'b1, mk(100, 3));
        check("lit_lvl_trig", W'(state_o), W'(2));
        check("lit_lvl_cnt", W'(captured_cnt), W'(1));
        beat(1'b1, mk(120, 4));
        // abort beats a coincident arm
        abort = 1'b1; arm = 1'b1;
        tick();
        abort = 1'b0; arm = 1'b0;
        check("lit_abort", W'(state_o), W'(0));
        rd(0, mk(100, 3), "lit_lvl_rd0");

        // no rising crossing from above, then a signed crossing from below
        do_arm(1'b1, 8, 100);
        beat(1'b1, mk(200, 5));
        beat(1'b1, mk(300, 6));
        check("lit_nocross", W'(state_o), W'(1));
        beat(1'b1, mk(-5, 7));
        check("lit_neg_wait", W'(state_o), W'(1));
        beat(1'b1, mk(100, 8));
        check("lit_neg_trig", W'(state_o), W'(2));
        abort = 1'b1; tick(); abort = 1'b0;

        // gapped valid: 1,0,1,0,1 with length 3
        do_arm(1'b0, 3, 0);
        for (int c = 0; c < 5; c++) begin
            beat(c % 2 == 0, mk(410 + c / 2, 41));
            if (c == 3) check("lit_gap_cap", W'(state_o), W'(2));
        end
        check("lit_gap_done", W'(state_o), W'(3));
        check("lit_gap_cnt", W'(captured_cnt), W'(3));

        // length 1 goes straight to DONE
        do_arm(1'b0, 1, 0);
        beat(1'b1, mk(1, 11));
        check("lit_len1", W'(state_o), W'(3));
        check("lit_len1_cnt", W'(captured_cnt), W'(1));

        // length 0 fills the buffer; read collides with write at address 1
        do_arm(1'b0, 0, 0);
        for (int k = 0; k < DEPTH; k++) begin
            if (k == 1) begin
                rd_en = 1'b1; rd_addr = AW'(1);
            end
            beat(1'b1, mk(k, k ^ 5));
            if (k == 1) begin
                rd_en = 1'b0;
                check("lit_collide_old", rd_data, mk(411, 41));
            end
        end
        check("lit_full_done", W'(state_o), W'(3));
        check("lit_full_cnt", W'(captured_cnt), W'(DEPTH));
        rd(DEPTH - 1, mk(DEPTH - 1, (DEPTH - 1) ^ 5), "lit_full_last");

        // oversize length clamps to the buffer depth
        do_arm(1'b0, 1500, 0);
        for (int k = 0; k < DEPTH; k++) begin
            beat(1'b1, mk(k, k + 77));
            if (k == DEPTH - 2) check("lit_clamp_cap", W'(state_o), W'(2));
        end
        check("lit_clamp_done", W'(state_o), W'(3));

        // reset mid-capture: beat on the reset edge is not written
        do_arm(1'b0, 8, 0);
        for (int k = 0; k < 5; k++) beat(1'b1, mk(k, 900));
        reset = 1'b1;
        beat(1'b1, mk(5, 900));
        reset = 1'b0;
        check("lit_midrst_state", W'(state_o), W'(0));
        check("lit_midrst_cnt", W'(captured_cnt), W'(0));
        rd(3, mk(3, 900), "lit_midrst_keep");
        rd(5, mk(5, 82), "lit_midrst_nowr");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
